v_regfile_grp: RTL
==================

// Module: v_regfile_grp
// PURPOSE
//  Parametrised vector register file for the vector coprocessor; successor to the fixed 32x128 regfile.
//  Adds a multi-beat LMUL group-write port (one register per cycle, valid/ready) and byte-enable masking.
//  Also: SEW-sized element read/write, N group-read ports and a v0 mask output. Sits between decode/issue and the lanes.
// PARAMETERS
//  VLEN          128  bits per vector register (multiple of ELEN)
//  NUM_REGS      32   architectural vector registers (power of 2)
//  ELEN          32   max element width; element data port width
//  NUM_RD_PORTS  2    independent group-read ports
//  MAX_LMUL      4    registers returned per group read; largest legal group write
// PORTS  (RW=$clog2(NUM_REGS), IW=$clog2(VLEN/8))
//  clk           in   1                        clock, rising edge
//  nrst          in   1                        asynchronous, active-low reset
//  wr_valid      in   1                        group-write beat valid
//  wr_ready      out  1                        group-write beat accepted when valid&ready
//  wr_addr       in   RW                       group base register (sampled on first beat only)
//  wr_lmul       in   3                        group size code (sampled on first beat only)
//  wr_data       in   VLEN                     beat data
//  wr_be         in   VLEN/8                   beat byte enables
//  wr_done       out  1                        1-cycle pulse after last beat written
//  wr_err        out  1                        1-cycle pulse: misaligned/oversize group rejected
//  el_wr_en      in   1                        element write request
//  el_wr_ready   out  1                        element write accepted
//  el_wr_reg     in   RW                       element target register
//  el_wr_idx     in   IW                       element index
//  el_sew        in   3                        element width code (shared by element read/write)
//  el_wr_data    in   ELEN                     element data, LSB-aligned
//  el_rd_reg     in   RW                       element read register
//  el_rd_idx     in   IW                       element read index
//  el_rd_data    out  ELEN                     element read data, zero-extended
//  rd_addr       in   NUM_RD_PORTS*RW          group-read base per port
//  rd_data       out  NUM_RD_PORTS*MAX_LMUL*VLEN  regs base..base+MAX_LMUL-1 per port
//  mask          out  VLEN                     contents of v0
// BEHAVIOUR
//  - Reset (async, nrst=0): all registers 0; FSM->IDLE; wr_ready=1, wr_done=0, wr_err=0, el_wr_ready=1.
//  - Codes: el_sew 000=8, 001=16, 010=32, else 8. wr_lmul 000=1, 001=2, 010=4, 011=8, else 1.
//  - FSM IDLE: first accepted beat latches base and n=group size.
//    - n>MAX_LMUL, or base%n!=0: beat dropped, wr_err pulses next cycle, stay IDLE.
//    - Otherwise beat 0 written to base; n=1 -> wr_done next cycle; n>1 -> BURST, cnt=1.
//  - BURST: accepted beat cnt written to base+cnt; wr_addr/wr_lmul ignored.
//    - cnt==n-1 -> IDLE, wr_done next cycle. wr_valid low holds state (no timeout).
//  - wr_ready=1 in IDLE and BURST (never back-pressures). Write lands at clock edge of acceptance.
//  - Byte lane b of target reg updated only where wr_be[b]=1.
//  - Element write: byte lanes idx*SEW/8..+SEW/8-1, data from el_wr_data[SEW-1:0].
//    - idx >= VLEN/SEW: silently ignored (el_wr_ready still 1).
//  - Conflict: el_wr_en and group beat in same cycle to same register -> el_wr_ready=0, element not written
//    (requester retries). Different registers: both written same edge.
//  - Reads combinational, no bypass: writes visible the cycle after the edge.
//  - Group-read index (base+j) mod NUM_REGS (wraps).
//  - el_rd_data = selected element zero-extended; 0 if idx out of range.
//  - mask = reg 0 continuously.
//  - Reset asserted mid-burst: burst abandoned, no wr_done; beats already written are cleared by reset anyway.
// STRUCTURE
//  - Package v_regfile_pkg: sew_e, lmul_e enums; functions sew_bits(), lmul_regs(); wr_state_e {IDLE,BURST}.
//  - Sub-module v_regfile_wr_seq: group-write FSM, beat counter, alignment check, wr_done/wr_err.
//    Outputs per-cycle target reg + byte-enable vector.
//  - Top: storage array, byte-enable merge of group beat and element write, read muxes.
// TESTING
//  1. nrst low mid-BURST (lmul=4, after beat 1) -> all rd_data 0, wr_done never pulses, next wr_addr=8 lmul=1 writes v8.
//  2. Group write base=4 lmul=010, 4 beats 0xA..,0xB..,0xC..,0xD.., wr_be all 1, gap cycle after beat 2
//     -> v4..v7 hold data; wr_done 1 cycle after beat 3; rd_addr=4 returns all four.
//  3. Group write base=5 lmul=001 -> wr_err pulse, v5/v6 unchanged.
//     lmul=011 with MAX_LMUL=4 -> wr_err.
//  4. el_sew=001, el_wr_reg=3, idx=5, data=0xBEEF -> v3[95:80]=0xBEEF, others unchanged; el_rd idx=5 -> 0x0000BEEF.
//     idx=8 -> write ignored, read returns 0.
//  5. Group beat to v2 and el write to v2 same cycle -> el_wr_ready=0, v2=beat data.
//     Retry next cycle -> element merged.
//  6. rd_addr=30 -> rd_data = v30,v31,v0,v1; write 0x5 to v0 -> mask=0x5 next cycle; wr_be=0x0001 updates byte 0 only.

Source files
------------

// File: rtl/v_regfile_pkg.sv
// Shared types and decode helpers for the vector register file.
// No ports. Provides:
//   sew_e      - element width codes (shared by element read and write)
//   lmul_e     - register group size codes
//   wr_state_e - group-write sequencer state
//   sew_bits() - element width code -> element width in bits (unknown codes -> 8)
//   lmul_regs()- group size code -> registers per group (unknown codes -> 1)
package v_regfile_pkg;

  typedef enum logic [2:0] {
    SEW8  = 3'b000,
    SEW16 = 3'b001,
    SEW32 = 3'b010
  } sew_e;

  typedef enum logic [2:0] {
    LMUL1 = 3'b000,
    LMUL2 = 3'b001,
    LMUL4 = 3'b010,
    LMUL8 = 3'b011
  } lmul_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } wr_state_e;

  function automatic int sew_bits(input logic [2:0] code);
    case (code)
      SEW16:   return 16;
      SEW32:   return 32;
      default: return 8;
    endcase
  endfunction

  function automatic logic [3:0] lmul_regs(input logic [2:0] code);
    case (code)
      LMUL2:   return 4'd2;
      LMUL4:   return 4'd4;
      LMUL8:   return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/v_regfile_wr_seq.sv
// Group-write sequencer: walks a multi-beat LMUL group write one register
// per beat, rejects oversize or misaligned groups, and reports completion.
// Ports:
//   clk, nrst         clock / asynchronous active-low reset
//   wr_valid          beat valid (accepted every cycle it is high)
//   wr_addr, wr_lmul  group base and size code, used on the first beat only
//   wr_be             beat byte enables, passed through to beat_be
//   wr_done, wr_err   registered 1-cycle pulses: group finished / group rejected
//   beat_we           a beat is written this cycle
//   beat_reg, beat_be target register and byte enables of this cycle's beat
//   state             current sequencer state (debug / observation)
module v_regfile_wr_seq
  import v_regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int MAX_LMUL = 4,
  parameter int NBYTES   = 16,
  localparam int RW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              wr_valid,
  input  logic [RW-1:0]     wr_addr,
  input  logic [2:0]        wr_lmul,
  input  logic [NBYTES-1:0] wr_be,
  output logic              wr_done,
  output logic              wr_err,
  output logic              beat_we,
  output logic [RW-1:0]     beat_reg,
  output logic [NBYTES-1:0] beat_be,
  output wr_state_e         state
);

  wr_state_e     state_nx;
  logic [RW-1:0] base_q, base_nx;
  logic [3:0]    n_q, n_nx;
  logic [3:0]    cnt_q, cnt_nx;
  logic [3:0]    n_req;
  logic          done_nx, err_nx;

  assign n_req   = lmul_regs(wr_lmul);
  assign beat_be = wr_be;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      base_q  <= '0;
      n_q     <= 4'd1;
      cnt_q   <= '0;
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      state   <= state_nx;
      base_q  <= base_nx;
      n_q     <= n_nx;
      cnt_q   <= cnt_nx;
      wr_done <= done_nx;
      wr_err  <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    base_nx  = base_q;
    n_nx     = n_q;
    cnt_nx   = cnt_q;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    beat_we  = 1'b0;
    beat_reg = base_q + RW'(cnt_q);
    case (state)
      IDLE: begin
        beat_reg = wr_addr;
        if (wr_valid) begin
          // Group sizes are powers of two, so base%n is the low log2(n) bits.
          if (int'(n_req) > MAX_LMUL || (wr_addr & RW'(n_req - 4'd1)) != '0) begin
            err_nx = 1'b1;
          end else begin
            beat_we = 1'b1;
            if (n_req == 4'd1) begin
              done_nx = 1'b1;
            end else begin
              state_nx = BURST;
              base_nx  = wr_addr;
              n_nx     = n_req;
              cnt_nx   = 4'd1;
            end
          end
        end
      end
      BURST: begin
        if (wr_valid) begin
          beat_we = 1'b1;
          if (cnt_q == n_q - 4'd1) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            cnt_nx = cnt_q + 4'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/v_regfile_grp.sv
// Parametrised vector register file with an LMUL group-write port,
// byte-enable masking, SEW-sized element access, group-read ports and v0 mask.
// Handshakes: a group beat transfers on every cycle with wr_valid&wr_ready
// (wr_ready is always 1); an element write transfers on el_wr_en&el_wr_ready,
// and the requester holds and retries while el_wr_ready is 0.
// Ports:
//   clk, nrst                  clock / asynchronous active-low reset
//   wr_valid/ready/addr/lmul/data/be, wr_done, wr_err   group-write port
//   el_wr_en/ready/reg/idx/data, el_sew                  element write (el_sew shared)
//   el_rd_reg, el_rd_idx, el_rd_data                     element read, zero-extended
//   rd_addr, rd_data           per port: regs base..base+MAX_LMUL-1 (wrapping),
//                              port p word j at rd_data[(p*MAX_LMUL+j)*VLEN +: VLEN]
//   mask                       contents of v0
// All reads are combinational from the array: a write is visible the cycle after its edge.
module v_regfile_grp
  import v_regfile_pkg::*;
#(
  parameter int VLEN         = 128,
  parameter int NUM_REGS     = 32,
  parameter int ELEN         = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int MAX_LMUL     = 4,
  localparam int RW          = $clog2(NUM_REGS),
  localparam int IW          = $clog2(VLEN/8),
  localparam int NB          = VLEN/8
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic [RW-1:0]                       wr_addr,
  input  logic [2:0]                          wr_lmul,
  input  logic [VLEN-1:0]                     wr_data,
  input  logic [NB-1:0]                       wr_be,
  output logic                                wr_done,
  output logic                                wr_err,
  input  logic                                el_wr_en,
  output logic                                el_wr_ready,
  input  logic [RW-1:0]                       el_wr_reg,
  input  logic [IW-1:0]                       el_wr_idx,
  input  logic [2:0]                          el_sew,
  input  logic [ELEN-1:0]                     el_wr_data,
  input  logic [RW-1:0]                       el_rd_reg,
  input  logic [IW-1:0]                       el_rd_idx,
  output logic [ELEN-1:0]                     el_rd_data,
  input  logic [NUM_RD_PORTS*RW-1:0]          rd_addr,
  output logic [NUM_RD_PORTS*MAX_LMUL*VLEN-1:0] rd_data,
  output logic [VLEN-1:0]                     mask
);

  logic [VLEN-1:0] regs [NUM_REGS];

  wr_state_e       wr_state;
  logic            beat_we;
  logic [RW-1:0]   beat_reg;
  logic [NB-1:0]   beat_be;

  v_regfile_wr_seq #(
    .NUM_REGS (NUM_REGS),
    .MAX_LMUL (MAX_LMUL),
    .NBYTES   (NB)
  ) u_wr_seq (
    .clk      (clk),
    .nrst     (nrst),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_lmul  (wr_lmul),
    .wr_be    (wr_be),
    .wr_done  (wr_done),
    .wr_err   (wr_err),
    .beat_we  (beat_we),
    .beat_reg (beat_reg),
    .beat_be  (beat_be),
    .state    (wr_state)
  );

  // The sequencer never back-pressures in either state.
  assign wr_ready = (wr_state == IDLE) || (wr_state == BURST);

  // Element write decode: byte lanes covered by the element, data pre-shifted.
  int              wsew, web;
  logic            el_in_rng, el_conflict, el_we;
  logic [NB-1:0]   el_be;
  logic [VLEN-1:0] el_vec;

  always_comb begin
    wsew        = sew_bits(el_sew);
    web         = wsew / 8;
    el_in_rng   = int'(el_wr_idx) < (VLEN / wsew);
    // The group beat wins a same-register collision; the element is retried.
    el_conflict = el_wr_en && beat_we && (beat_reg == el_wr_reg);
    el_we       = el_wr_en && !el_conflict && el_in_rng;
    el_vec      = VLEN'(el_wr_data) << (int'(el_wr_idx) * wsew);
    for (int b = 0; b < NB; b++) begin
      el_be[b] = el_we && (b >= int'(el_wr_idx) * web) &&
                 (b < (int'(el_wr_idx) + 1) * web);
    end
  end

  assign el_wr_ready = !el_conflict;

  // Storage: both writers merge per byte lane; they never target the same
  // register in the same cycle because a collision suppresses the element.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        for (int b = 0; b < NB; b++) begin
          if (beat_we && beat_reg == RW'(r) && beat_be[b]) begin
            regs[r][b*8 +: 8] <= wr_data[b*8 +: 8];
          end else if (el_wr_reg == RW'(r) && el_be[b]) begin
            regs[r][b*8 +: 8] <= el_vec[b*8 +: 8];
          end
        end
      end
    end
  end

  // Group reads: register index wraps modulo NUM_REGS through RW-bit truncation.
  always_comb begin
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      for (int j = 0; j < MAX_LMUL; j++) begin
        rd_data[(p*MAX_LMUL + j)*VLEN +: VLEN] = regs[rd_addr[p*RW +: RW] + RW'(j)];
      end
    end
  end

  // Element read: shift the element to bit 0, then clear bits above SEW.
  int              rsew;
  logic [VLEN-1:0] rsel;
  logic [ELEN-1:0] rmask;

  always_comb begin
    rsew = sew_bits(el_sew);
    rsel = regs[el_rd_reg] >> (int'(el_rd_idx) * rsew);
    for (int i = 0; i < ELEN; i++) rmask[i] = (i < rsew);
    el_rd_data = (int'(el_rd_idx) < (VLEN / rsew)) ? (rsel[ELEN-1:0] & rmask) : '0;
  end

  assign mask = regs[0];

endmodule
